// File: rtl/prog2_dm_loader.sv
// Data-memory front end for the program-2 processor: streams 64 operand bytes in, presets
// the result/scratch area, runs the processor until done, then reads back Min/Max results.
module prog2_dm_loader #(
  parameter int N_BYTES    = 64,
  parameter int MIN_ADDR   = 66,
  parameter int MEM_TOP    = 255,
  parameter int DONE_BLANK = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        dm_we,
  output logic [7:0]  dm_addr,
  output logic [7:0]  dm_wdata,
  input  logic [7:0]  dm_rdata,
  output logic        cpu_reset,
  input  logic        cpu_done,
  output logic        res_valid,
  output logic [15:0] res_min,
  output logic [15:0] res_max,
  output logic [7:0]  set_count
);

  localparam logic [7:0] LAST_BYTE = 8'(N_BYTES - 1);
  localparam logic [7:0] MIN_A     = 8'(MIN_ADDR);
  localparam logic [7:0] TOP_A     = 8'(MEM_TOP);
  localparam logic [7:0] BLANK     = 8'(DONE_BLANK);

  typedef enum logic [2:0] {
    LOAD   = 3'd0,
    CLEAR  = 3'd1,
    RUN    = 3'd2,
    READ   = 3'd3,
    REPORT = 3'd4
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       armed;
  logic       accept;
  logic [7:0] byte_cnt;
  logic [7:0] clr_addr;
  logic [7:0] blank_cnt;
  logic [1:0] rd_idx;

  // armed keeps in_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= LOAD;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    accept    = 1'b0;
    dm_we     = 1'b0;
    dm_addr   = 8'd0;
    dm_wdata  = 8'd0;
    cpu_reset = 1'b1;
    res_valid = 1'b0;
    case (state)
      LOAD: begin
        in_ready = armed;
        accept   = in_valid & armed;
        dm_addr  = byte_cnt;
        if (accept) begin
          dm_we    = 1'b1;
          dm_wdata = in_data;
          if (byte_cnt == LAST_BYTE) state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        dm_we    = 1'b1;
        dm_addr  = clr_addr;
        dm_wdata = (clr_addr == MIN_A || clr_addr == MIN_A + 8'd1) ? 8'hFF : 8'h00;
        if (clr_addr == TOP_A) state_nxt = RUN;
      end
      RUN: begin
        cpu_reset = 1'b0;
        if (blank_cnt == BLANK && cpu_done) state_nxt = READ;
      end
      READ: begin
        dm_addr = MIN_A + {6'd0, rd_idx};
        if (rd_idx == 2'd3) state_nxt = REPORT;
      end
      REPORT: begin
        res_valid = 1'b1;
        state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_cnt  <= 8'd0;
      clr_addr  <= 8'd0;
      blank_cnt <= 8'd0;
      rd_idx    <= 2'd0;
      res_min   <= 16'd0;
      res_max   <= 16'd0;
      set_count <= 8'd0;
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            if (byte_cnt == LAST_BYTE) begin
              byte_cnt <= 8'd0;
              clr_addr <= MIN_A;
            end else begin
              byte_cnt <= byte_cnt + 8'd1;
            end
          end
        end
        CLEAR: begin
          clr_addr <= clr_addr + 8'd1;
          if (clr_addr == TOP_A) begin
            blank_cnt <= 8'd0;
            rd_idx    <= 2'd0;
          end
        end
        RUN: begin
          if (blank_cnt != BLANK) blank_cnt <= blank_cnt + 8'd1;
        end
        READ: begin
          case (rd_idx)
            2'd0:    res_min[15:8] <= dm_rdata;
            2'd1:    res_min[7:0]  <= dm_rdata;
            2'd2:    res_max[15:8] <= dm_rdata;
            default: res_max[7:0]  <= dm_rdata;
          endcase
          rd_idx <= rd_idx + 2'd1;
          // count advances on entry to REPORT so it is current during the pulse
          if (rd_idx == 2'd3) set_count <= set_count + 8'd1;
        end
        REPORT: byte_cnt <= 8'd0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog2_dm_loader.sv
// Scoreboard bench for prog2_dm_loader with a data-memory and processor model.
module tb_prog2_dm_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        cpu_done = 1'b0;
  logic        in_ready, dm_we, cpu_reset, res_valid;
  logic [7:0]  dm_addr, dm_wdata, dm_rdata, set_count;
  logic [15:0] res_min, res_max;

  logic [7:0]  mem [256];
  logic        mem_init = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [15:0] cpu_min = 16'd0;
  logic [15:0] cpu_max = 16'd0;
  logic        prev_vld = 1'b0;

  typedef struct packed {
    logic [15:0] mn;
    logic [15:0] mx;
    logic [7:0]  cnt;
  } exp_t;
  exp_t exp_q[$];

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int exp_sets = 0;

  logic [15:0] min_tab [10] = '{16'h8000, 16'hFFFF, 16'h0000, 16'h1234, 16'h00FF,
                                16'hFF00, 16'h0001, 16'h7FFF, 16'hA5A5, 16'h5A5A};
  logic [15:0] max_tab [10] = '{16'h7FFF, 16'h0001, 16'hFFFE, 16'h4321, 16'hFF00,
                                16'h00FF, 16'h8001, 16'h0000, 16'h3C3C, 16'hC3C3};

  prog2_dm_loader dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
    .cpu_reset(cpu_reset), .cpu_done(cpu_done), .res_valid(res_valid),
    .res_min(res_min), .res_max(res_max), .set_count(set_count)
  );

  always #5 clk = ~clk;

  assign dm_rdata = mem[dm_addr];

  // processor results land in 66..69 in one shot while it owns memory
  always @(posedge clk) begin
    if (mem_init) begin
      for (int a = 0; a < 256; a++) mem[a] <= 8'hA5;
    end else if (dm_we) begin
      mem[dm_addr] <= dm_wdata;
    end else if (cpu_wr) begin
      mem[66] <= cpu_min[15:8];
      mem[67] <= cpu_min[7:0];
      mem[68] <= cpu_max[15:8];
      mem[69] <= cpu_max[7:0];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: actual %0h required %0h", name, act, req);
  endtask

  function automatic logic [7:0] dat(input int k, input int i);
    return 8'(i + 17 * k);
  endfunction

  always @(negedge clk) begin
    if (res_valid) begin
      if (exp_q.size() == 0) begin
        check("res_unexpected", exp_q.size(), 1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("res_min", res_min, e.mn);
        check("res_max", res_max, e.mx);
        check("set_count", set_count, e.cnt);
        check("cpu_reset_report", cpu_reset, 1);
        check("res_single_pulse", prev_vld, 0);
      end
    end
    prev_vld <= res_valid;
  end

  // ends on the first CLEAR cycle with in_valid dropped
  task automatic load_set(input int k, input bit gap);
    for (int i = 0; i < 64; i++) begin
      if (gap && i == 21) begin
        for (int g = 0; g < 10; g++) begin
          @(negedge clk);
          in_valid = 1'b0;
          #1;
          check("gap_no_write", {in_ready, dm_we}, 2'b10);
        end
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = dat(k, i);
      #1;
      check("load_write", {in_ready, dm_we, dm_addr, dm_wdata}, {1'b1, 1'b1, 8'(i), dat(k, i)});
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
  endtask

  task automatic run_set(input int k, input bit gap, input bit early,
                         input logic [15:0] mn, input logic [15:0] mx);
    int n, bad, lat;
    load_set(k, gap);
    check("clear_first", {in_ready, dm_we, dm_addr, dm_wdata}, {1'b0, 1'b1, 8'd66, 8'hFF});
    n = 1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!cpu_reset) break;
      n++;
    end
    check("clear_len", n, 190);
    #1;
    bad = 0;
    for (int a = 0; a < 256; a++) begin
      if (a < 64) begin if (mem[a] !== dat(k, a)) bad++; end
      else if (a < 66) begin if (mem[a] !== 8'hA5) bad++; end
      else if (a < 68) begin if (mem[a] !== 8'hFF) bad++; end
      else if (mem[a] !== 8'h00) bad++;
    end
    check("mem_after_clear", bad, 0);
    cpu_min = mn;
    cpu_max = mx;
    cpu_wr  = 1'b1;
    exp_sets++;
    exp_q.push_back('{mn: mn, mx: mx, cnt: 8'(exp_sets)});
    if (early) begin
      cpu_done = 1'b1;
      n = 1;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        cpu_wr = 1'b0;
        if (cpu_reset) break;
        n++;
      end
      check("early_run_len", n, 3);
      for (int c = 0; c < 20 && !res_valid; c++) @(negedge clk);
      check("early_res_seen", res_valid, 1);
    end else begin
      repeat (4) begin
        @(negedge clk);
        cpu_wr = 1'b0;
      end
      cpu_done = 1'b1;
      lat = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        lat++;
        if (res_valid) break;
      end
      check("done_to_valid", lat, 5);
    end
    cpu_done = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    mem_init = 1'b1;
    repeat (3) @(negedge clk);
    mem_init = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_dm", {dm_we, dm_addr, dm_wdata}, 17'd0);
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_res", {res_valid, res_min, res_max, set_count}, 41'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("in_ready_after_release", in_ready, 1);

    run_set(0, 1'b0, 1'b0, 16'h0003, 16'h7FF0);

    load_set(30, 1'b0);
    for (int c = 0; c < 300 && !(dm_we && dm_addr == 8'd100); c++) @(negedge clk);
    check("mid_reach_100", dm_addr, 100);
    reset = 1'b0;
    #1;
    check("mid_in_ready", in_ready, 0);
    check("mid_dm", {dm_we, dm_addr, dm_wdata}, 17'd0);
    check("mid_cpu_reset", cpu_reset, 1);
    check("mid_res", {res_valid, res_min, res_max, set_count}, 41'd0);
    exp_sets = 0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("mid_in_ready_release", in_ready, 1);

    for (int j = 0; j < 10; j++)
      run_set(j + 1, j == 0, j == 1, min_tab[j], max_tab[j]);

    @(negedge clk);
    #1;
    check("final_set_count", set_count, 10);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
